if_stage: RTL and testbench

//  Fetch stage of the 5-stage RV32 core: PC register, instruction-memory request FSM and IF/ID register.

---
 rtl/if_stage_pkg.sv | 17 +
 rtl/if_stage_if_id_reg.sv | 35 +++
 rtl/if_stage.sv | 141 ++++++++++++++
 tb/tb_if_stage.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: data width, NOP encoding, fetch FSM states.
// Imported by if_stage and if_id_reg.
package if_stage_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: pc, instruction and valid bit handed to decode.
// Priority rst > flush (pc kept) > load > hold; no added latency beyond the register.
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         load,
  input  logic [W-1:0] pc_in,
  input  logic [W-1:0] inst_in,
  input  logic         valid_in,
  output logic [W-1:0] pc_d,
  output logic [W-1:0] inst_d,
  output logic         valid_d
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_d    <= '0;
      inst_d  <= NOP_INST;
      valid_d <= 1'b0;
    end else if (flush) begin
      inst_d  <= NOP_INST;
      valid_d <= 1'b0;
    end else if (load) begin
      pc_d    <= pc_in;
      inst_d  <= inst_in;
      valid_d <= valid_in;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Fetch stage: PC register, single-outstanding imem request FSM, hold buffer and IF/ID register.
// Build option IF_MISALIGN_CHK_EN enables the sticky misaligned-redirect flag.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_en,
  input  logic            de_en,
  input  logic            de_rst,
  input  logic            taken,
  input  logic [XLEN-1:0] target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] inst_d,
  output logic            valid_d,
  output logic            misalign
);
  import if_stage_pkg::*;

  state_t            state, state_nx;
  logic [XLEN-1:0]   pc, pc_nx, pc_inc, tgt;
  logic [XLEN-1:0]   drop_addr, drop_addr_nx;
  logic [XLEN-1:0]   hold_pc, hold_inst;
  logic              hold_ld, adv;
  logic              idl_load, idl_flush, idl_valid;
  logic [XLEN-1:0]   idl_pc, idl_inst;

  // A disagreeing if_en/de_en pair is a stall, never a partial advance.
  assign adv       = if_en && de_en;
  assign tgt       = {target[XLEN-1:2], 2'b00};
  assign pc_inc    = pc + XLEN'(4);
  assign idl_flush = de_rst || taken;

  assign imem_req  = (state == S_REQ) || (state == S_DROP);
  assign imem_addr = (state == S_DROP) ? drop_addr : pc;

  always_comb begin
    state_nx     = state;
    pc_nx        = pc;
    drop_addr_nx = drop_addr;
    hold_ld      = 1'b0;
    idl_load     = 1'b0;
    idl_pc       = pc;
    idl_inst     = NOP_INST;
    idl_valid    = 1'b0;
    case (state)
      S_IDLE: begin
        state_nx = S_REQ;
        if (taken) pc_nx = tgt;
      end
      S_REQ: begin
        if (taken) begin
          pc_nx = tgt;
          if (!imem_ready) begin
            // Request cannot be withdrawn: keep presenting the old address.
            state_nx     = S_DROP;
            drop_addr_nx = pc;
          end
        end else if (imem_ready) begin
          pc_nx = pc_inc;
          if (adv) begin
            idl_load  = 1'b1;
            idl_inst  = imem_rdata;
            idl_valid = 1'b1;
          end else begin
            hold_ld  = 1'b1;
            state_nx = S_HOLD;
          end
        end else begin
          idl_load = de_en;
        end
      end
      S_HOLD: begin
        if (taken) begin
          pc_nx    = tgt;
          state_nx = S_REQ;
        end else if (adv) begin
          idl_load  = 1'b1;
          idl_pc    = hold_pc;
          idl_inst  = hold_inst;
          idl_valid = 1'b1;
          state_nx  = S_REQ;
        end
      end
      S_DROP: begin
        if (taken) pc_nx = tgt;
        if (imem_ready) state_nx = S_REQ;
        idl_load = de_en;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      drop_addr <= '0;
      hold_pc   <= '0;
      hold_inst <= NOP_INST;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      drop_addr <= drop_addr_nx;
      if (hold_ld) begin
        hold_pc   <= pc;
        hold_inst <= imem_rdata;
      end
    end
  end

  if_id_reg #(.W(XLEN)) u_if_id (
    .clk      (clk),
    .rst      (rst),
    .flush    (idl_flush),
    .load     (idl_load),
    .pc_in    (idl_pc),
    .inst_in  (idl_inst),
    .valid_in (idl_valid),
    .pc_d     (pc_d),
    .inst_d   (inst_d),
    .valid_d  (valid_d)
  );

`ifdef IF_MISALIGN_CHK_EN
  always_ff @(posedge clk) begin
    if (rst)                         misalign <= 1'b0;
    else if (taken && |target[1:0])  misalign <= 1'b1;
  end
`else
  logic unused_tgt_lsb;
  assign unused_tgt_lsb = ^target[1:0];
  assign misalign       = 1'b0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed cycle table for if_stage: reset, streaming, stalls, redirects during imem wait, wrap, misalign.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst, if_en, de_en, de_rst, taken, imem_ready;
  logic [31:0] target;
  logic        imem_req, valid_d, misalign;
  logic [31:0] imem_addr, imem_rdata, pc_d, inst_d;

  int errs   = 0;
  int checks = 0;

`ifdef IF_MISALIGN_CHK_EN
  localparam bit M = 1'b1;
`else
  localparam bit M = 1'b0;
`endif

  localparam logic [31:0] INST_OFS = 32'h1000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  always #5 clk = ~clk;

  // Instruction memory returns an address-derived word so origin is traceable.
  assign imem_rdata = imem_addr + INST_OFS;

  if_stage #(.RESET_PC(32'h0), .XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_en      (if_en),
    .de_en      (de_en),
    .de_rst     (de_rst),
    .taken      (taken),
    .target     (target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .pc_d       (pc_d),
    .inst_d     (inst_d),
    .valid_d    (valid_d),
    .misalign   (misalign)
  );

  typedef struct {
    bit          r, ie, de, dr, tk;
    logic [31:0] tg;
    bit          rdy;
    bit          cp, rq;
    logic [31:0] ad;
    bit          vl;
    logic [31:0] pcd;
    bit          ms;
  } vec_t;

  vec_t v[$];

  function automatic vec_t mk(bit r, bit ie, bit de, bit dr, bit tk, logic [31:0] tg, bit rdy,
                              bit cp, bit rq, logic [31:0] ad, bit vl, logic [31:0] pcd, bit ms);
    vec_t t;
    t.r = r; t.ie = ie; t.de = de; t.dr = dr; t.tk = tk; t.tg = tg; t.rdy = rdy;
    t.cp = cp; t.rq = rq; t.ad = ad; t.vl = vl; t.pcd = pcd; t.ms = ms;
    return t;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
    end
  endtask

  bit          pend;
  logic [31:0] pend_addr;

  initial begin
    //            r ie de dr tk tgt           rdy  cp rq addr          vl pc_d          ms
    v.push_back(mk(1,1,1,0,0,32'h0,          1,   0,0,32'h0,         0,32'h0,         0)); // 0 reset
    v.push_back(mk(1,1,1,0,0,32'h0,          1,   0,0,32'h0,         0,32'h0,         0));
    v.push_back(mk(1,1,1,0,0,32'h0,          1,   0,0,32'h0,         0,32'h0,         0));
    v.push_back(mk(0,1,1,0,0,32'h0,          1,   1,0,32'h0,         0,32'h0,         0)); // 3 idle
    v.push_back(mk(0,1,1,0,0,32'h0,          1,   1,1,32'h0,         1,32'h0,         0)); // 4 stream
    v.push_back(mk(0,1,1,0,0,32'h0,          1,   1,1,32'h4,         1,32'h4,         0));
    v.push_back(mk(0,0,0,0,0,32'h0,          1,   1,1,32'h8,         1,32'h4,         0)); // 6 stall->hold
    v.push_back(mk(0,0,0,0,0,32'h0,          1,   1,0,32'h0,         1,32'h4,         0));
    v.push_back(mk(0,0,0,0,0,32'h0,          1,   1,0,32'h0,         1,32'h4,         0));
    v.push_back(mk(0,1,1,0,0,32'h0,          1,   1,0,32'h0,         1,32'h8,         0)); // 9 release
    v.push_back(mk(0,1,1,0,0,32'h0,          1,   1,1,32'hC,         1,32'hC,         0));
    v.push_back(mk(0,1,1,0,0,32'h0,          0,   1,1,32'h10,        0,32'h0,         0)); // 11 wait
    v.push_back(mk(0,1,1,0,1,32'h40,         0,   1,1,32'h10,        0,32'h0,         0)); // 12 taken->drop
    v.push_back(mk(0,1,1,0,0,32'h0,          0,   1,1,32'h10,        0,32'h0,         0));
    v.push_back(mk(0,1,1,0,0,32'h0,          0,   1,1,32'h10,        0,32'h0,         0));
    v.push_back(mk(0,1,1,0,0,32'h0,          1,   1,1,32'h10,        0,32'h0,         0)); // 15 drain
    v.push_back(mk(0,1,1,0,0,32'h0,          1,   1,1,32'h40,        1,32'h40,        0));
    v.push_back(mk(0,1,0,0,1,32'h80,         1,   1,1,32'h44,        0,32'h0,         0)); // 17 taken+stall
    v.push_back(mk(0,1,1,0,0,32'h0,          1,   1,1,32'h80,        1,32'h80,        0));
    v.push_back(mk(0,1,1,0,1,32'h42,         1,   1,1,32'h84,        0,32'h0,         M)); // 19 misaligned
    v.push_back(mk(0,1,1,0,0,32'h0,          1,   1,1,32'h40,        1,32'h40,        M));
    v.push_back(mk(0,1,1,0,1,32'h100,        0,   1,1,32'h44,        0,32'h0,         M)); // 21 drop
    v.push_back(mk(1,1,1,0,0,32'h0,          0,   1,1,32'h44,        0,32'h0,         0)); // 22 rst in drop
    v.push_back(mk(0,1,1,0,0,32'h0,          1,   1,0,32'h0,         0,32'h0,         0));
    v.push_back(mk(0,1,1,0,0,32'h0,          1,   1,1,32'h0,         1,32'h0,         0));
    v.push_back(mk(0,1,1,0,1,32'hFFFF_FFFC,  1,   1,1,32'h4,         0,32'h0,         0)); // 25 wrap
    v.push_back(mk(0,1,1,0,0,32'h0,          1,   1,1,32'hFFFF_FFFC, 1,32'hFFFF_FFFC, 0));
    v.push_back(mk(0,1,1,0,0,32'h0,          1,   1,1,32'h0,         1,32'h0,         0));
    v.push_back(mk(0,0,0,0,0,32'h0,          1,   1,1,32'h4,         1,32'h0,         0)); // 28 hold
    v.push_back(mk(0,0,0,1,1,32'h200,        1,   1,0,32'h0,         0,32'h0,         0)); // 29 taken in hold
    v.push_back(mk(0,1,1,0,0,32'h0,          0,   1,1,32'h200,       0,32'h0,         0));
    v.push_back(mk(0,1,1,0,1,32'h300,        0,   1,1,32'h200,       0,32'h0,         0)); // 31 drop
    v.push_back(mk(0,1,1,0,1,32'h310,        0,   1,1,32'h200,       0,32'h0,         0)); // 32 latest wins
    v.push_back(mk(0,1,1,0,0,32'h0,          1,   1,1,32'h200,       0,32'h0,         0));
    v.push_back(mk(0,1,1,0,0,32'h0,          1,   1,1,32'h310,       1,32'h310,       0));
    v.push_back(mk(0,1,0,0,0,32'h0,          1,   1,1,32'h314,       1,32'h310,       0)); // 35 disagree
    v.push_back(mk(0,1,1,0,0,32'h0,          1,   1,0,32'h0,         1,32'h314,       0));
    v.push_back(mk(0,1,1,0,0,32'h0,          1,   1,1,32'h318,       1,32'h318,       0));

    rst = 1'b1; if_en = 1'b1; de_en = 1'b1; de_rst = 1'b0; taken = 1'b0;
    target = '0; imem_ready = 1'b1;
    pend = 1'b0; pend_addr = '0;

    for (int i = 0; i < v.size(); i++) begin
      @(negedge clk);
      rst = v[i].r; if_en = v[i].ie; de_en = v[i].de; de_rst = v[i].dr;
      taken = v[i].tk; target = v[i].tg; imem_ready = v[i].rdy;
      #1;
      if (v[i].cp) begin
        chk("imem_req", i, {31'b0, imem_req}, {31'b0, v[i].rq});
        if (v[i].rq) chk("imem_addr", i, imem_addr, v[i].ad);
      end
      // An unanswered request must persist unchanged into this cycle.
      if (pend) begin
        chk("req_held", i, {31'b0, imem_req}, 32'd1);
        chk("addr_held", i, imem_addr, pend_addr);
      end
      pend      = v[i].cp && imem_req && !v[i].rdy && !v[i].r;
      pend_addr = imem_addr;
      @(posedge clk);
      #1;
      chk("valid_d", i, {31'b0, valid_d}, {31'b0, v[i].vl});
      chk("inst_d", i, inst_d, v[i].vl ? v[i].pcd + INST_OFS : NOP);
      if (v[i].vl || v[i].r) chk("pc_d", i, pc_d, v[i].pcd);
      chk("misalign", i, {31'b0, misalign}, {31'b0, v[i].ms});
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
